// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared types and default widths for the ALU request scheduler
package alu_sched_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int OP_W_DEF    = 4;
  localparam int FLAG_W_DEF  = 4;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [OP_W_DEF-1:0]   op;
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
  } alu_cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin arbiter
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      // On contention the requester that did not win last time goes next.
      if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
      else              gnt = req;
    end
    gnt_id = gnt[1];
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// rtl/alu_req_scheduler.sv - shares one ALU between two requesters, with timeout and tagged response
module alu_req_scheduler
  import alu_sched_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int FLAG_W  = FLAG_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              alu_start,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              rsp_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_e             state_q, state_d;
  logic               rr_last_q, rr_last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic               id_q, id_d;
  logic [DATA_W-1:0]  res_q, res_d;
  logic [FLAG_W-1:0]  flags_q, flags_d;
  logic               err_q, err_d;

  logic [1:0]         gnt;
  logic               gnt_id;
  logic               arb_en;

  // Held-off during reset so no ready escapes while rst_n is low.
  assign arb_en = ena & rst_n & (state_q == IDLE);

  rr_arb2 u_arb (
    .req    ({req1_valid, req0_valid}),
    .last   (rr_last_q),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    id_d      = id_q;
    res_d     = res_q;
    flags_d   = flags_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          op_d      = gnt_id ? req1_op : req0_op;
          a_d       = gnt_id ? req1_a  : req0_a;
          b_d       = gnt_id ? req1_b  : req0_b;
          id_d      = gnt_id;
          rr_last_d = gnt_id;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Completion takes precedence over a timeout landing on the same cycle.
        if (alu_done) begin
          res_d   = alu_result;
          flags_d = alu_flags;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          res_d   = '0;
          flags_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      res_q     <= '0;
      flags_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      id_q      <= id_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
      err_q     <= err_d;
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign alu_start  = (state_q == ISSUE);
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_req_scheduler.sv
// tb/tb_alu_req_scheduler.sv - directed-vector bench for alu_req_scheduler
module tb_alu_req_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       req0_valid, req0_ready;
  logic [3:0] req0_op;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [3:0] req1_op;
  logic [7:0] req1_a, req1_b;
  logic       alu_start;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic       alu_done;
  logic [7:0] alu_result;
  logic [3:0] alu_flags;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_req_scheduler #(.DATA_W(8), .OP_W(4), .FLAG_W(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .busy(busy)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    alu_done = 0; alu_result = 0; alu_flags = 0; rsp_ready = 0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    check_vec("rst_busy", busy, 0);
    check_vec("rst_rsp_valid", rsp_valid, 0);
    check_vec("rst_alu_start", alu_start, 0);
    check_vec("rst_alu_a", alu_a, 0);
    check_vec("rst_ready0", req0_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention: alternation starts with req0 after reset
    req0_valid = 1; req0_op = 4'h1; req0_a = 8'h10; req0_b = 8'h01;
    req1_valid = 1; req1_op = 4'h2; req1_a = 8'h20; req1_b = 8'h02;
    rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_vec("rr_ready0", req0_ready, (k % 2) == 0);
      check_vec("rr_ready1", req1_ready, (k % 2) == 1);
      @(negedge clk);
      check_vec("rr_start", alu_start, 1);
      check_vec("rr_alu_a", alu_a, (k % 2) ? 8'h20 : 8'h10);
      @(negedge clk);
      alu_done = 1; alu_result = (k % 2) ? 8'h22 : 8'h11;
      @(negedge clk);
      alu_done = 0;
      check_vec("rr_rsp_valid", rsp_valid, 1);
      check_vec("rr_rsp_id", rsp_id, k % 2);
      check_vec("rr_rsp_result", rsp_result, (k % 2) ? 8'h22 : 8'h11);
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;

    // Single request, ALU done on second WAIT cycle
    req0_valid = 1; req0_op = 4'h0; req0_a = 8'h12; req0_b = 8'h34;
    #1;
    check_vec("s_ready0", req0_ready, 1);
    check_vec("s_ready1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 0;
    check_vec("s_start", alu_start, 1);
    check_vec("s_op", alu_op, 4'h0);
    check_vec("s_a", alu_a, 8'h12);
    check_vec("s_b", alu_b, 8'h34);
    check_vec("s_ready0_once", req0_ready, 0);
    @(negedge clk);
    check_vec("s_start_once", alu_start, 0);
    check_vec("s_busy", busy, 1);
    @(negedge clk);
    alu_done = 1; alu_result = 8'h46; alu_flags = 4'h0;
    @(negedge clk);
    alu_done = 0;
    check_vec("s_rsp_valid", rsp_valid, 1);
    check_vec("s_rsp_id", rsp_id, 0);
    check_vec("s_rsp_result", rsp_result, 8'h46);
    check_vec("s_rsp_err", rsp_err, 0);
    check_vec("s_alu_a_held", alu_a, 8'h12);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check_vec("s_idle_valid", rsp_valid, 0);
    check_vec("s_idle_busy", busy, 0);

    // Timeout with a stray done pulse during ISSUE
    req0_valid = 1; req0_op = 4'h3; req0_a = 8'h55; req0_b = 8'h01;
    #1;
    check_vec("t_ready0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 0; alu_done = 1; alu_result = 8'h77; alu_flags = 4'hF;
    @(negedge clk);
    alu_done = 0;
    for (int i = 0; i < 16; i++) begin
      check_vec("t_no_rsp", rsp_valid, 0);
      @(negedge clk);
    end
    check_vec("t_rsp_valid", rsp_valid, 1);
    check_vec("t_rsp_err", rsp_err, 1);
    check_vec("t_rsp_result", rsp_result, 8'h00);
    check_vec("t_rsp_flags", rsp_flags, 4'h0);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;

    // Done on the very cycle the timeout would expire
    req0_valid = 1; req0_op = 4'h3; req0_a = 8'h66; req0_b = 8'h02;
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        alu_done = 1; alu_result = 8'hAA; alu_flags = 4'hA;
      end
      @(negedge clk);
    end
    alu_done = 0;
    check_vec("te_rsp_valid", rsp_valid, 1);
    check_vec("te_rsp_err", rsp_err, 0);
    check_vec("te_rsp_result", rsp_result, 8'hAA);
    check_vec("te_rsp_flags", rsp_flags, 4'hA);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;

    // Backpressure with req1 pending
    req0_valid = 1; req0_op = 4'h1; req0_a = 8'h03; req0_b = 8'h04;
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    alu_done = 1; alu_result = 8'h07; alu_flags = 4'h0;
    @(negedge clk);
    alu_done = 0;
    req1_valid = 1; req1_op = 4'h5; req1_a = 8'h09; req1_b = 8'h0A;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_vec("bp_rsp_valid", rsp_valid, 1);
      check_vec("bp_rsp_result", rsp_result, 8'h07);
      check_vec("bp_rsp_id", rsp_id, 0);
      check_vec("bp_busy", busy, 1);
      check_vec("bp_ready1", req1_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    #1;
    check_vec("bp_grant1", req1_ready, 1);
    @(negedge clk);
    req1_valid = 0;
    check_vec("bp_alu_a1", alu_a, 8'h09);
    @(negedge clk);
    alu_done = 1; alu_result = 8'h13;
    @(negedge clk);
    alu_done = 0;
    check_vec("bp_rsp_id1", rsp_id, 1);
    check_vec("bp_rsp_res1", rsp_result, 8'h13);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;

    // ena low blocks grants; dropping it mid-flight still completes
    ena = 0;
    req0_valid = 1; req0_op = 4'h0; req0_a = 8'h21; req0_b = 8'h01;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_vec("en_no_grant", req0_ready, 0);
      check_vec("en_not_busy", busy, 0);
      @(negedge clk);
    end
    ena = 1;
    #1;
    check_vec("en_grant", req0_ready, 1);
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    ena = 0;
    @(negedge clk);
    alu_done = 1; alu_result = 8'h22; alu_flags = 4'h0;
    @(negedge clk);
    alu_done = 0;
    check_vec("en_rsp_valid", rsp_valid, 1);
    check_vec("en_rsp_result", rsp_result, 8'h22);
    check_vec("en_rsp_err", rsp_err, 0);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    req0_valid = 1;
    #1;
    check_vec("en_idle_block", req0_ready, 0);
    @(negedge clk);
    check_vec("en_idle_busy", busy, 0);
    req0_valid = 0; ena = 1;

    // Asynchronous reset while in WAIT
    req0_valid = 1; req0_op = 4'h7; req0_a = 8'h5A; req0_b = 8'hA5;
    #1;
    check_vec("ar_ready0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    check_vec("ar_in_wait", busy, 1);
    #2;
    rst_n = 0;
    req0_valid = 1; req1_valid = 1;
    #1;
    check_vec("ar_busy", busy, 0);
    check_vec("ar_alu_op", alu_op, 0);
    check_vec("ar_alu_a", alu_a, 0);
    check_vec("ar_alu_start", alu_start, 0);
    check_vec("ar_rsp_valid", rsp_valid, 0);
    check_vec("ar_rsp_result", rsp_result, 0);
    check_vec("ar_ready0", req0_ready, 0);
    check_vec("ar_ready1", req1_ready, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    check_vec("ar_first0", req0_ready, 1);
    check_vec("ar_first1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    check_vec("ar_issue_a", alu_a, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Shares the single ALU datapath in tt_alu_top between two requesters (req0, req1) using round-robin arbitration.
- Latches the granted request's opcode and operands and issues a one-cycle start pulse to the ALU.
- Waits for ALU completion, bounded by a timeout, then returns a tagged response on a valid/ready port.
- Sits between the pin-decode front end and the ALU core inside tt_alu_top.

Parameters:
- DATA_W, 8, operand/result width.
- OP_W, 4, ALU opcode width.
- FLAG_W, 4, ALU flag width (Z, N, C, V).
- TIMEOUT, 16, max WAIT cycles before an error response; must be ≥2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design enable; gates new grants only.
- req0_valid  in  1  requester 0 has a command.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_op  in  OP_W  requester 0 opcode.
- req0_a  in  DATA_W  requester 0 operand A.
- req0_b  in  DATA_W  requester 0 operand B.
- req1_valid / req1_ready / req1_op / req1_a / req1_b  same as req0 for requester 1.
- alu_start  out  1  one-cycle issue pulse.
- alu_op  out  OP_W  latched opcode.
- alu_a  out  DATA_W  latched operand A.
- alu_b  out  DATA_W  latched operand B.
- alu_done  in  1  ALU result valid.
- alu_result  in  DATA_W  ALU result.
- alu_flags  in  FLAG_W  ALU flags.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  DATA_W  captured result.
- rsp_flags  out  FLAG_W  captured flags.
- rsp_err  out  1  response is a timeout.
- busy  out  1  state is not IDLE.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Reset drives every output and register to 0: state=IDLE, rr_last=1 (so req0 has first priority), wait counter 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If ena=1 and any reqN_valid=1, grant one requester.
  - Only one valid: grant it.
  - Both valid: grant the one that is not rr_last.
  - In the grant cycle: assert reqN_ready for that requester (combinational, single cycle), latch op/a/b and id, set rr_last=id, go to ISSUE.
  - ena=0: no grant, both readys stay 0, remain in IDLE.
- ISSUE: alu_start=1 for exactly one cycle, counter cleared, go to WAIT. alu_op/alu_a/alu_b hold the latched values from ISSUE through the end of WAIT, and stay held after that.
- WAIT:
  - alu_done is sampled only in WAIT, so minimum ALU latency is 1 cycle.
  - alu_done=1: capture alu_result and alu_flags, rsp_err=0, go to RESP.
  - No done: counter increments each cycle. When counter reaches TIMEOUT-1 without done: rsp_result=0, rsp_flags=0, rsp_err=1, go to RESP.
  - alu_done in the same cycle as timeout expiry: done wins, rsp_err=0.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result, rsp_flags, rsp_err held stable until rsp_ready=1.
  - On handshake go to IDLE; the next grant happens no earlier than the following cycle.
  - alu_done pulses outside WAIT are ignored.
- Throughput: best case one command per 4 cycles (IDLE grant → ISSUE → WAIT with done → RESP with rsp_ready=1).
- ena deasserted mid-operation: the in-flight command completes normally; only new grants are blocked.
- A requester dropping valid before it is granted is legal; it is simply not granted.
- Asynchronous reset mid-operation: return immediately to reset values. The pending response is discarded and no ready is asserted.

Decomposition:
- Package alu_sched_pkg holds:
  - state_e enum {IDLE, ISSUE, WAIT, RESP};
  - typedef alu_cmd_t struct {op, a, b};
  - localparams for the default widths.
- One sub-module, rr_arb2: a 2-input round-robin arbiter with inputs req[1:0], last, en and outputs gnt[1:0], gnt_id. It is combinational; the rr_last register stays in the parent.

Test Plan:
- Single request: req0 op=ADD a=0x12 b=0x34, ALU returns done after 2 cycles with 0x46, flags 0 → req0_ready pulses once, alu_start pulses 1 cycle later, rsp_valid with id=0, result=0x46, err=0.
- Contention: req0 and req1 both valid continuously, ALU latency 1 → grants alternate 0,1,0,1 starting with 0 after reset; rsp_id follows the same sequence.
- Timeout: alu_done never asserted → rsp_valid after TIMEOUT=16 WAIT cycles with err=1, result=0x00; same cycle as expiry with done=1 and result=0xAA → err=0, result=0xAA.
- Backpressure: rsp_ready=0 for 5 cycles → rsp_* stable, busy=1, no req_ready on a pending req1; release → req1 granted next cycle.
- ena=0 with req0 valid → no grant for 10 cycles; drop ena while in WAIT → response still delivered.
- Asynchronous reset asserted in WAIT → all outputs 0 immediately; after release, req1 and req0 both valid → req0 granted first.
